// File: rtl/output_pkg.sv
// Shared definitions for the delayed output stage: default widths, the age-width
// helper and the buffer entry record.
package output_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int MAX_DELAY_DEF = 15;

    // Width needed to hold any hold time 0..max_delay.
    function automatic int delay_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    localparam int AGE_W_DEF = $clog2(MAX_DELAY_DEF + 1);

    // Entry record at the default configuration.
    typedef struct packed {
        logic                  valid;
        logic [AGE_W_DEF-1:0]  age;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/age_counter_sat.sv
// Per-entry age counter: cleared when its entry is written, then counts up once
// per cycle while the entry is occupied, saturating at MAX_DELAY.
module age_counter_sat
    import output_pkg::*;
#(
    parameter  int MAX_DELAY = MAX_DELAY_DEF,
    localparam int AGE_W     = delay_w(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [AGE_W-1:0] age
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (en && (age != AGE_W'(MAX_DELAY))) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/delay_out_buffer.sv
// Order-preserving output buffer that holds each beat for a programmable number
// of cycles before offering it downstream.
module delay_out_buffer
    import output_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int DEPTH     = 4,
    parameter  int MAX_DELAY = MAX_DELAY_DEF,
    localparam int AGE_W     = delay_w(MAX_DELAY),
    localparam int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AGE_W-1:0]  delay_cfg,
    input  logic              flush,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [AGE_W-1:0]  age_q  [DEPTH];
    logic [AGE_W-1:0]  deff;
    logic              push;
    logic              pop;

    // Hold times beyond what the counters can reach are clamped, not rejected.
    assign deff = (delay_cfg > AGE_W'(MAX_DELAY)) ? AGE_W'(MAX_DELAY) : delay_cfg;

    assign ready_in  = (level_q != LVL_W'(DEPTH));
    assign valid_out = (level_q != '0) && valid_q[rd_ptr] && (age_q[rd_ptr] >= deff);
    assign data_out  = data_q[rd_ptr];
    assign level     = level_q;

    // Flush wins over both handshakes in the same cycle.
    assign push = valid_in && ready_in && !flush;
    assign pop  = valid_out && ready_out && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            valid_q <= '0;
        end else begin
            // Push needs not-full and pop needs not-empty, so the slots never collide.
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                data_q[wr_ptr]  <= data_in;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        age_counter_sat #(
            .MAX_DELAY (MAX_DELAY)
        ) u_age (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (push && (wr_ptr == PTR_W'(i))),
            .en    (valid_q[i]),
            .age   (age_q[i])
        );
    end

endmodule

// File: tb/tb_delay_out_buffer.sv
// Bench for delay_out_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the hold/release rules.
module tb_delay_out_buffer;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int MAX_DELAY = 12;
    localparam int AGE_W     = $clog2(MAX_DELAY + 1);
    localparam int LVL_W     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AGE_W-1:0]  delay_cfg = '0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_out = 1'b0;
    logic [LVL_W-1:0]  level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DATA_W-1:0] exp_q [$];
    int                exp_t [$];

    delay_out_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .MAX_DELAY (MAX_DELAY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .delay_cfg (delay_cfg),
        .flush     (flush),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .level     (level)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    // A beat is released once min(cycles since push, MAX_DELAY) reaches the clamped
    // delay; the queue front is the only candidate.
    always @(negedge clk) begin
        int  deff;
        int  age;
        bit  e_valid;
        bit  e_ready;
        if (!rst_n) begin
            exp_q.delete();
            exp_t.delete();
            chk("rst_level", level, 0);
            chk("rst_valid_out", valid_out, 0);
            chk("rst_ready_in", ready_in, 1);
            chk("rst_data_out", data_out, 0);
        end else begin
            deff    = (int'(delay_cfg) > MAX_DELAY) ? MAX_DELAY : int'(delay_cfg);
            e_ready = (exp_q.size() < DEPTH);
            e_valid = 1'b0;
            if (exp_q.size() > 0) begin
                age     = cyc - exp_t[0];
                if (age > MAX_DELAY) age = MAX_DELAY;
                e_valid = (age >= deff);
            end
            chk("level", level, exp_q.size());
            chk("ready_in", ready_in, e_ready);
            chk("valid_out", valid_out, e_valid);
            if (e_valid) chk("data_out", data_out, exp_q[0]);
            if (flush) begin
                exp_q.delete();
                exp_t.delete();
            end else begin
                if (e_valid && ready_out) begin
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                end
                if (valid_in && e_ready) begin
                    exp_q.push_back(data_in);
                    exp_t.push_back(cyc + 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Source behaviour: hold the beat until it is accepted.
    task automatic push_beat(input logic [DATA_W-1:0] d);
        bit acc;
        int guard;
        acc      = 1'b0;
        guard    = 0;
        data_in  = d;
        valid_in = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: beat %0h not accepted after %0d cycles", d, guard);
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < budget) begin
            step(1);
            g++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d beats left, required 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Single beat, D=2.
        delay_cfg = 2;
        ready_out = 1'b1;
        push_beat(8'hA5);
        wait_drain(20);
        step(2);

        // D=0 back-to-back stream.
        delay_cfg = 0;
        for (int i = 1; i <= 8; i++) push_beat(DATA_W'(i));
        wait_drain(20);
        step(2);

        // Fill with downstream stalled; fifth beat waits at the source.
        delay_cfg = 1;
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) push_beat(8'h11 + DATA_W'(i));
        fork
            push_beat(8'h15);
            begin
                step(6);
                ready_out = 1'b1;
            end
        join
        wait_drain(20);
        step(2);

        // Clamp above MAX_DELAY, then a long stall that saturates the age.
        delay_cfg = 15;
        push_beat(8'hC3);
        wait_drain(30);
        ready_out = 1'b0;
        push_beat(8'hC4);
        step(40);
        ready_out = 1'b1;
        wait_drain(5);
        step(2);

        // Lowering the delay releases already-aged beats in one burst.
        delay_cfg = 10;
        push_beat(8'h31);
        push_beat(8'h32);
        push_beat(8'h33);
        step(2);
        delay_cfg = 2;
        wait_drain(10);
        step(2);

        // Raising the delay withdraws a released head.
        delay_cfg = 1;
        ready_out = 1'b0;
        push_beat(8'h41);
        step(3);
        delay_cfg = 9;
        step(3);
        ready_out = 1'b1;
        wait_drain(20);

        // Flush with beats buffered and a simultaneous input beat.
        delay_cfg = 5;
        for (int i = 0; i < 3; i++) push_beat(8'h51 + DATA_W'(i));
        flush    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hEE;
        step(1);
        flush    = 1'b0;
        valid_in = 1'b0;
        step(10);

        // Asynchronous reset mid-stream.
        delay_cfg = 3;
        push_beat(8'h61);
        push_beat(8'h62);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_out", valid_out, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_ready_in", ready_in, 1);
        chk("async_rst_data_out", data_out, 0);
        step(2);
        rst_n = 1'b1;
        step(6);

        // Random traffic.
        acc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!valid_in || acc) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = DATA_W'($urandom);
            end
            ready_out = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) delay_cfg = AGE_W'($urandom_range(0, 15));
            flush = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            acc = valid_in && (ready_in || flush);
            @(posedge clk);
            #1;
        end
        valid_in  = 1'b0;
        flush     = 1'b0;
        ready_out = 1'b1;
        wait_drain(100);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
